// File: rtl/dh_shared_key.sv
// Diffie-Hellman shared key K = R2^x mod p via left-to-right square-and-multiply
// with bit-serial interleaved modular multiplies. Option: DH_KEY_SKIP_LZ_EN skips leading zeros of x.
module dh_shared_key #(
   parameter int W  = 32,
   parameter int EW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st,
   input  logic [W-1:0]  r_in,
   input  logic [EW-1:0] x,
   input  logic [W-1:0]  p,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  key,
   output logic          err
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int RW = $clog2(EW + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RED, S_SQR, S_MUL, S_FIN, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  r_q, r_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  p_q, p_d;
   logic [W-1:0]  base_q, base_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  key_q, key_d;
   logic [EW-1:0] xs_q, xs_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   // One interleaved shift-add step: r = (2r mod p + a_msb*b) mod p.
   logic [W:0]   dbl, pw, dbl_red, sum;
   logic [W-1:0] res;
   logic         last;

   always_comb begin
      pw      = {1'b0, p_q};
      dbl     = {r_q, 1'b0};
      dbl_red = (dbl >= pw) ? dbl - pw : dbl;
      sum     = dbl_red + (a_q[W-1] ? {1'b0, b_q} : '0);
      res     = (sum >= pw) ? W'(sum - pw) : sum[W-1:0];
      last    = (cnt_q == '0);
   end

`ifdef DH_KEY_SKIP_LZ_EN
   // Number of exponent bits from the MSB set bit down to bit 0.
   logic [RW-1:0] x_len;
   always_comb begin
      x_len = '0;
      for (int i = 0; i < EW; i++) begin
         if (x[i]) x_len = RW'(i + 1);
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      base_d  = base_q;
      acc_d   = acc_q;
      key_d   = key_q;
      xs_d    = xs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (st) begin
               err_d = 1'b0;
               p_d   = p;
               a_d   = r_in;
               b_d   = W'(1);
               r_d   = '0;
               cnt_d = CW'(W - 1);
`ifdef DH_KEY_SKIP_LZ_EN
               xs_d  = x << (EW - int'(x_len));
               rem_d = x_len;
`else
               xs_d  = x;
               rem_d = RW'(EW);
`endif
               state_d = (p[W-1:1] == '0) ? S_ERR : S_RED;
            end
         end

         S_RED, S_SQR, S_MUL: begin
            r_d   = res;
            a_d   = a_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (last) begin
               r_d   = '0;
               cnt_d = CW'(W - 1);
               if (state_q == S_RED) begin
                  base_d = res;
                  acc_d  = W'(1);
                  a_d    = W'(1);
                  b_d    = W'(1);
                  state_d = (rem_q == '0) ? S_FIN : S_SQR;
               end else begin
                  acc_d = res;
                  if (state_q == S_SQR && xs_q[EW-1]) begin
                     a_d     = res;
                     b_d     = base_q;
                     state_d = S_MUL;
                  end else begin
                     // Current exponent bit finished; move to the next one.
                     xs_d  = xs_q << 1;
                     rem_d = rem_q - RW'(1);
                     a_d   = res;
                     b_d   = res;
                     state_d = (rem_q == RW'(1)) ? S_FIN : S_SQR;
                  end
               end
            end
         end

         S_FIN: begin
            done_d  = 1'b1;
            key_d   = acc_q;
            state_d = S_IDLE;
         end

         S_ERR: begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            key_d   = '0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         base_q  <= '0;
         acc_q   <= '0;
         key_q   <= '0;
         xs_q    <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         key_q   <= key_d;
         xs_q    <= xs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign key  = key_q;
   assign err  = err_q;

endmodule

// File: tb/tb_dh_shared_key.sv
// Directed bench for dh_shared_key (W=32, EW=32); honours DH_KEY_SKIP_LZ_EN for latencies.
module tb_dh_shared_key;

   logic        clk;
   logic        rst;
   logic        st;
   logic [31:0] r_in;
   logic [31:0] x;
   logic [31:0] p;
   logic        busy;
   logic        done;
   logic [31:0] key;
   logic        err;

   int checks = 0;
   int errors = 0;

   dh_shared_key #(.W(32), .EW(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .st   (st),
      .r_in (r_in),
      .x    (x),
      .p    (p),
      .busy (busy),
      .done (done),
      .key  (key),
      .err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Latency from the edge sampling st to the cycle done is high.
   function automatic int exp_lat(input logic [31:0] xv);
      int pc;
      int m;
      pc = $countones(xv);
      m  = -1;
      for (int i = 0; i < 32; i++) if (xv[i]) m = i;
`ifdef DH_KEY_SKIP_LZ_EN
      if (xv == 0) return 33;
      return 32 * (1 + (m + 1) + pc) + 1;
`else
      return 32 * (1 + 32 + pc) + 1;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] rv, input logic [31:0] xv, input logic [31:0] pv);
      @(negedge clk);
      r_in = rv;
      x    = xv;
      p    = pv;
      st   = 1'b1;
      @(posedge clk);
      #1;
      st   = 1'b0;
      r_in = $urandom;
      x    = $urandom;
      p    = $urandom;
      check("busy_after_st", {63'b0, busy}, 64'd1);
      check("err_clr_on_st", {63'b0, err}, 64'd0);
   endtask

   task automatic wait_done(input int limit, inout int n, output logic got);
      got = 1'b0;
      while (!got && n < limit) begin
         @(posedge clk);
         n++;
         #1;
         check("busy_done_excl", {63'b0, busy & done}, 64'd0);
         if (done) got = 1'b1;
      end
      check("done_seen", {63'b0, got}, 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [31:0] rv, input logic [31:0] xv,
                         input logic [31:0] pv, input logic [31:0] exp_key,
                         input logic exp_err, input int exp_n);
      int   n;
      logic got;
      start_op(rv, xv, pv);
      n = 0;
      wait_done(4000, n, got);
      check({tag, "_key"}, {32'b0, key}, {32'b0, exp_key});
      check({tag, "_err"}, {63'b0, err}, {63'b0, exp_err});
      check({tag, "_lat"}, 64'(n), 64'(exp_n));
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
      check({tag, "_key_held"}, {32'b0, key}, {32'b0, exp_key});
   endtask

   initial begin
      int   n;
      logic got;
      logic seen;

      rst  = 1'b0;
      st   = 1'b0;
      r_in = '0;
      x    = '0;
      p    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_key",  {32'b0, key},  64'd0);
      check("rst_err",  {63'b0, err},  64'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("t1", 32'd6, 32'd3, 32'd17, 32'd12, 1'b0, exp_lat(32'd3));
      run_op("t2a", 32'd10, 32'd4, 32'd23, 32'd18, 1'b0, exp_lat(32'd4));
      run_op("t2b", 32'd4, 32'd3, 32'd23, 32'd18, 1'b0, exp_lat(32'd3));
      run_op("t3a", 32'd40, 32'd1, 32'd17, 32'd6, 1'b0, exp_lat(32'd1));
      run_op("t3b", 32'd34, 32'd5, 32'd17, 32'd0, 1'b0, exp_lat(32'd5));
      run_op("t3c", 32'd9, 32'd0, 32'd17, 32'd1, 1'b0, exp_lat(32'd0));
      run_op("t3d", 32'd0, 32'd7, 32'd17, 32'd0, 1'b0, exp_lat(32'd7));
      run_op("t4a", 32'hFFFFFFFA, 32'd2, 32'hFFFFFFFB, 32'd1, 1'b0, exp_lat(32'd2));
      run_op("t4b", 32'hFFFFFFFA, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFA, 1'b0, exp_lat(32'd3));

      run_op("t5p1", 32'd5, 32'd3, 32'd1, 32'd0, 1'b1, 1);
      run_op("t5p0", 32'd5, 32'd3, 32'd0, 32'd0, 1'b1, 1);
      run_op("t5ok", 32'd6, 32'd3, 32'd17, 32'd12, 1'b0, exp_lat(32'd3));

      // A second start while busy must be ignored.
      start_op(32'd10, 32'd4, 32'd23);
      n = 0;
      repeat (100) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      st   = 1'b1;
      r_in = 32'd6;
      x    = 32'd3;
      p    = 32'd17;
      @(posedge clk);
      n++;
      #1;
      st = 1'b0;
      wait_done(4000, n, got);
      check("t6_ign_key", {32'b0, key}, 64'd18);
      check("t6_ign_lat", 64'(n), 64'(exp_lat(32'd4)));

      // Reset in the middle of a run aborts it.
      start_op(32'd6, 32'd3, 32'd17);
      repeat (499) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("t6_rst_busy", {63'b0, busy}, 64'd0);
      check("t6_rst_done", {63'b0, done}, 64'd0);
      check("t6_rst_key",  {32'b0, key},  64'd0);
      check("t6_rst_err",  {63'b0, err},  64'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (1200) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      check("t6_no_done_after_abort", {63'b0, seen}, 64'd0);
      run_op("t6_after", 32'd4, 32'd3, 32'd23, 32'd18, 1'b0, exp_lat(32'd3));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
